matrix_stream_reader: RTL
=========================

Name: matrix_stream_reader

Overview:
- Readout side of the 4x4 byte-matrix path: holds a DIMxDIM matrix of DATA_W-bit elements and streams it out one element per accepted handshake.
- Matrix is loaded by random-access writes, then streamed on a start pulse, row-major (col fastest).
- Keeps a running modulo-2^DATA_W checksum of emitted bytes, directly comparable with the sum produced on the fill side.
- Sits between matrix storage/fill logic and a downstream valid/ready consumer.

Parameters:
- DATA_W, 8, element width in bits.
- DIM, 4, matrix dimension; power of two >= 2; index width IDX_W = log2(DIM).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  write strobe into storage.
- wr_row  input  IDX_W  write row index.
- wr_col  input  IDX_W  write column index.
- wr_data  input  DATA_W  write data.
- start  input  1  single-cycle request to begin a stream.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  consumer accepts the current element.
- out_data  output  DATA_W  current element.
- out_row  output  IDX_W  row index of out_data.
- out_col  output  IDX_W  column index of out_data.
- out_last  output  1  current element is the final one of the stream.
- busy  output  1  high in STREAM.
- done  output  1  one-cycle pulse after the final handshake.
- checksum  output  DATA_W  sum of bytes emitted in the current/last stream.

Behaviour:
- Reset (async): state=IDLE; out_valid, out_last, busy, done = 0; out_data, out_row, out_col, checksum = 0; storage cleared to 0.
- States: IDLE, STREAM, DONE.
- IDLE:
  - wr_en writes storage[wr_row][wr_col] at the clock edge.
  - start=1: go to STREAM; checksum cleared; out_valid=1 with element [0][0] from the next cycle (1-cycle latency).
  - start and wr_en in the same cycle: start has priority, write dropped.
- STREAM:
  - Handshake = out_valid & out_ready.
  - Without a handshake, out_data/out_row/out_col/out_last are held stable and out_valid stays 1.
  - On a handshake, checksum += out_data (wraps mod 2^DATA_W), then advance to the next element and present it the following cycle with no bubble (back-to-back at full rate).
  - Order: col increments; when col wraps from DIM-1 to 0, row increments.
  - out_last=1 only for element [DIM-1][DIM-1].
  - Handshake on the last element: out_valid=0 next cycle, go to DONE.
  - busy=1 throughout STREAM.
  - wr_en and start are ignored.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in this cycle. checksum holds its final value until the next start.
- Reset during STREAM: abort immediately, no done pulse; all outputs take reset values.
- Full stream: exactly DIM*DIM handshakes; minimum DIM*DIM+2 cycles from start to done.

Optional Feature:
- Macro MATRIX_READER_COLMAJOR_EN.
- Defined: adds input port col_major (1 bit), sampled only when start is accepted. col_major=1 gives column-major order (row fastest); out_last still marks [DIM-1][DIM-1]; the checksum is unchanged since the same set of bytes is emitted.
- Undefined: port absent; row-major only.

Decomposition:
- Package matrix_pkg holds:
  - DATA_W and DIM defaults, IDX_W;
  - state enum type (IDLE/STREAM/DONE);
  - element and index typedefs, shared with the fill-side block.
- One natural sub-module, matrix_index_counter: row/col counter with advance, clear and optional col_major inputs, plus a last flag. Storage and FSM stay in the top.

Test Plan:
- Load element [r][c]=r*4+c+1, pulse start, out_ready held 1 -> 16 consecutive beats 0x01..0x10 in row-major order; out_last on beat 16; done pulse 1 cycle later; checksum=0x88.
- Same load, out_ready toggled 1,0,0,1 pattern -> data/indices stable while stalled, no loss or duplication, checksum=0x88.
- Load all cells 0x20 -> checksum wraps: 16*0x20 = 0x200, so checksum=0x00.
- During STREAM, pulse start and wr_en to [0][0]=0xFF -> stream unaffected; after done, a new start emits 0x01 at [0][0] (write was dropped).
- Assert rst at beat 5 -> out_valid, busy, checksum go 0 asynchronously, no done; storage cleared, so a restart emits all zeros.
- With MATRIX_READER_COLMAJOR_EN and col_major=1 -> order 0x01,0x05,0x09,0x0D,0x02,...,0x10; out_last on 0x10; checksum=0x88.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and defaults for the byte-matrix fill/readout path.
package matrix_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIM_DEF    = 4;
  localparam int IDX_W_DEF  = $clog2(DIM_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef logic [DATA_W_DEF-1:0] elem_t;
  typedef logic [IDX_W_DEF-1:0]  idx_t;

endpackage

// File: rtl/matrix_index_counter.sv
// Row/column walker for matrix readout; order is latched on clear.
module matrix_index_counter #(
  parameter  int DIM   = 4,
  localparam int IDX_W = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic             col_major,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic mode_cm;

  // DIM is a power of two, so the fast index wraps to 0 on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      col     <= '0;
      mode_cm <= 1'b0;
    end else if (clear) begin
      row     <= '0;
      col     <= '0;
      mode_cm <= col_major;
    end else if (advance) begin
      if (mode_cm) begin
        row <= row + IDX_ONE;
        if (row == IDX_MAX) col <= col + IDX_ONE;
      end else begin
        col <= col + IDX_ONE;
        if (col == IDX_MAX) row <= row + IDX_ONE;
      end
    end
  end

  assign last = (row == IDX_MAX) && (col == IDX_MAX);

endmodule

// File: rtl/matrix_stream_reader.sv
// Matrix storage plus valid/ready streamer with running byte checksum.
// Optional column-major ordering: define MATRIX_READER_COLMAJOR_EN.
//
// state  | meaning
// IDLE   | storage writable, waiting for start
// STREAM | presenting elements, advancing on each handshake
// DONE   | one-cycle done pulse, start ignored
module matrix_stream_reader
  import matrix_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DIM    = DIM_DEF,
  localparam int IDX_W  = $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_row,
  input  logic [IDX_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
`ifdef MATRIX_READER_COLMAJOR_EN
  input  logic              col_major,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_row,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DIM][DIM];
  logic [IDX_W-1:0]  row, col;
  logic              last_idx;
  logic              start_acc;
  logic              hs;
  logic              col_major_sel;

`ifdef MATRIX_READER_COLMAJOR_EN
  assign col_major_sel = col_major;
`else
  assign col_major_sel = 1'b0;
`endif

  assign start_acc = (state_q == IDLE) && start;
  assign hs        = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (hs && last_idx) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  matrix_index_counter #(.DIM(DIM)) u_idx (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_acc),
    .advance   (hs),
    .col_major (col_major_sel),
    .row       (row),
    .col       (col),
    .last      (last_idx)
  );

  // Start wins over a coincident write; writes outside IDLE are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          mem[r][c] <= '0;
    end else if ((state_q == IDLE) && wr_en && !start) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            checksum <= '0;
    else if (start_acc) checksum <= '0;
    else if (hs)        checksum <= checksum + out_data;
  end

  // Storage is frozen during STREAM, so a direct read stays stable under stall.
  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign done      = (state_q == DONE);
  assign out_data  = out_valid ? mem[row][col] : '0;
  assign out_row   = row;
  assign out_col   = col;
  assign out_last  = out_valid && last_idx;

endmodule
